// File: rtl/xbar_bank_arbiter.sv
// Crossbar arbiter between multiplier-output sources and accumulate-buffer banks.
// Each bank runs its own credit-gated round-robin; a small FSM frames each tile.
module xbar_bank_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int NUM_DST = 4,
    parameter int CREDITS = 4,
    localparam int CW = $clog2(CREDITS + 1),
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DW = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            req_valid,
    input  logic [NUM_SRC-1:0][DW-1:0]    req_dst,
    input  logic [NUM_DST-1:0]            credit_return,
    output logic [NUM_SRC-1:0]            grant,
    output logic [NUM_DST-1:0]            dst_valid,
    output logic [NUM_DST-1:0][SW-1:0]    dst_src,
    output logic                          src_stall,
    output logic                          busy,
    output logic                          tile_done,
    output logic                          credit_err
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t state_q;
    logic   busy_q;
    logic   tile_done_q;
    logic   credit_err_q;
    logic   credit_err_d;
    logic   grant_en;
    logic   all_full;

    logic [NUM_DST-1:0]         bank_hit;
    logic [NUM_DST-1:0][SW-1:0] bank_win;
    logic [NUM_DST-1:0]         bank_full;
    logic [NUM_DST-1:0]         bank_overflow;

    assign grant_en = (state_q == ACTIVE) || (state_q == DRAIN);
    assign all_full = &bank_full;

    for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_bank
        logic [NUM_SRC-1:0] cand;
        logic               raw_hit;
        logic [SW-1:0]      raw_win;
        logic [CW-1:0]      credit_d, credit_q;
        logic [SW-1:0]      rr_d, rr_q;
        logic [SW-1:0]      src_d, src_q;
        logic               valid_d, valid_q;

        always_comb begin
            cand = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                cand[s] = req_valid[s] && (req_dst[s] == DW'(gi));
            end
        end

        // Rotating search starting at rr_q; the first candidate found wins.
        always_comb begin
            int idx;
            raw_hit = 1'b0;
            raw_win = '0;
            idx     = 0;
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_SRC) begin
                    idx = idx - NUM_SRC;
                end
                if (!raw_hit && cand[idx]) begin
                    raw_hit = 1'b1;
                    raw_win = SW'(idx);
                end
            end
        end

        // The decision uses the registered count, so a return at zero cannot grant this cycle.
        assign bank_hit[gi] = raw_hit && grant_en && (credit_q != '0);
        assign bank_win[gi] = raw_win;

        always_comb begin
            credit_d           = credit_q;
            bank_overflow[gi]  = 1'b0;
            rr_d               = rr_q;
            src_d              = src_q;
            valid_d            = bank_hit[gi];
            if (bank_hit[gi] && !credit_return[gi]) begin
                credit_d = credit_q - CW'(1);
            end else if (!bank_hit[gi] && credit_return[gi]) begin
                if (credit_q == CW'(CREDITS)) begin
                    bank_overflow[gi] = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            if (bank_hit[gi]) begin
                rr_d  = (raw_win == SW'(NUM_SRC - 1)) ? '0 : raw_win + SW'(1);
                src_d = raw_win;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                credit_q <= CW'(CREDITS);
                rr_q     <= '0;
                src_q    <= '0;
                valid_q  <= 1'b0;
            end else begin
                credit_q <= credit_d;
                rr_q     <= rr_d;
                src_q    <= src_d;
                valid_q  <= valid_d;
            end
        end

        assign bank_full[gi] = (credit_q == CW'(CREDITS));
        assign dst_valid[gi] = valid_q;
        assign dst_src[gi]   = src_q;
    end

    always_comb begin
        grant = '0;
        for (int d = 0; d < NUM_DST; d++) begin
            if (bank_hit[d]) begin
                grant[bank_win[d]] = 1'b1;
            end
        end
    end

    assign src_stall    = |(req_valid & ~grant);
    assign credit_err_d = credit_err_q | (|bank_overflow);

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_err_q <= 1'b0;
        end else begin
            credit_err_q <= credit_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tile_done_q <= 1'b0;
                    if (start) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!(|req_valid) && all_full) begin
                        state_q     <= DONE;
                        tile_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    tile_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign tile_done  = tile_done_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Bench for xbar_bank_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_xbar_bank_arbiter;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            flush;
    logic [3:0]      req_valid;
    logic [3:0][1:0] req_dst;
    logic [3:0]      credit_return;
    logic [3:0]      grant;
    logic [3:0]      dst_valid;
    logic [3:0][1:0] dst_src;
    logic            src_stall;
    logic            busy;
    logic            tile_done;
    logic            credit_err;

    int checks = 0;
    int errors = 0;

    xbar_bank_arbiter #(.NUM_SRC(4), .NUM_DST(4), .CREDITS(4)) dut (
        .clock(clock), .reset(reset), .start(start), .flush(flush),
        .req_valid(req_valid), .req_dst(req_dst), .credit_return(credit_return),
        .grant(grant), .dst_valid(dst_valid), .dst_src(dst_src),
        .src_stall(src_stall), .busy(busy), .tile_done(tile_done),
        .credit_err(credit_err)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Leaves the caller at a negedge with reset released and inputs idle.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        req_valid = '0; req_dst = '0; credit_return = '0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic begin_tile();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        req_valid = 4'b0101; req_dst = '0; credit_return = '0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, tile_done, credit_err, dst_valid, dst_src, grant, src_stall} !==
            {1'b0, 1'b0, 1'b0, 4'b0, 8'b0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b dv=%b ds=%h grant=%b stall=%b required 0 0 0 0000 00 0000 1",
                     busy, tile_done, credit_err, dst_valid, dst_src, grant, src_stall);
        end
        @(posedge clock); #1;
        checks++;
        if ({busy, grant, src_stall} !== {1'b0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle_grant: got busy=%b grant=%b stall=%b required 0 0000 1", busy, grant, src_stall);
        end
        @(negedge clock);
        req_valid = '0;
        $display("test_reset done");
    endtask

    task automatic test_rr_same_bank();
        do_reset();
        begin_tile();
        req_valid = 4'hF;
        req_dst   = {4{2'd1}};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (grant !== 4'(1 << i) || src_stall !== (i < 3)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got grant=%b stall=%b required %b %b", i, grant, src_stall, 4'(1 << i), (i < 3));
            end
            @(posedge clock); #1;
            checks++;
            if (dst_valid !== 4'b0010 || dst_src[1] !== 2'(i)) begin
                errors++;
                $display("FAIL rr_dst[%0d]: got dv=%b src=%0d required 0010 %0d", i, dst_valid, dst_src[1], i);
            end
            $display("txn rr: bank 1 <- src %0d", dst_src[1]);
            @(negedge clock);
            req_valid[i] = 1'b0;
        end
        @(posedge clock); #1;
        checks++;
        if (dst_valid !== 4'b0) begin
            errors++;
            $display("FAIL rr_idle_dv: got %b required 0000", dst_valid);
        end
        @(negedge clock);
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        begin_tile();
        req_valid  = 4'b0001;
        req_dst[0] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (grant !== ((i < 4) ? 4'b0001 : 4'b0000) || src_stall !== (i >= 4)) begin
                errors++;
                $display("FAIL credit_cycle[%0d]: got grant=%b stall=%b required %b %b",
                         i, grant, src_stall, (i < 4) ? 4'b0001 : 4'b0000, (i >= 4));
            end
            @(posedge clock);
            @(negedge clock);
        end
        credit_return = 4'b0100;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL credit_zero_return: got grant=%b required 0000", grant);
        end
        @(posedge clock);
        @(negedge clock);
        credit_return = '0;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL credit_regrant: got grant=%b required 0001", grant);
        end
        @(posedge clock); #1;
        checks++;
        if (dst_valid !== 4'b0100 || dst_src[2] !== 2'd0) begin
            errors++;
            $display("FAIL credit_regrant_dst: got dv=%b src=%0d required 0100 0", dst_valid, dst_src[2]);
        end
        @(negedge clock); #1;
        checks++;
        if (grant !== 4'b0000 || src_stall !== 1'b1) begin
            errors++;
            $display("FAIL credit_reexhaust: got grant=%b stall=%b required 0000 1", grant, src_stall);
        end
        req_valid = '0;
        $display("test_credit_exhaust done");
    endtask

    task automatic test_parallel();
        do_reset();
        begin_tile();
        req_valid = 4'hF;
        req_dst   = {2'd3, 2'd2, 2'd1, 2'd0};
        #1;
        checks++;
        if (grant !== 4'hF || src_stall !== 1'b0) begin
            errors++;
            $display("FAIL parallel_grant: got grant=%b stall=%b required 1111 0", grant, src_stall);
        end
        @(posedge clock); #1;
        checks++;
        if (dst_valid !== 4'hF || dst_src !== {2'd3, 2'd2, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL parallel_dst: got dv=%b ds=%h required 1111 e4", dst_valid, dst_src);
        end
        $display("txn parallel: dv=%b ds=%h", dst_valid, dst_src);
        @(negedge clock);
        req_valid = '0;
    endtask

    task automatic test_drain();
        do_reset();
        begin_tile();
        req_valid  = 4'b0001;
        req_dst[0] = 2'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (grant !== 4'b0001) begin
                errors++;
                $display("FAIL drain_fill[%0d]: got grant=%b required 0001", i, grant);
            end
            @(posedge clock);
            @(negedge clock);
        end
        req_valid = '0;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            credit_return = (i == 2 || i == 4) ? 4'b0001 : 4'b0000;
            @(posedge clock); #1;
            checks++;
            if (busy !== 1'b1 || tile_done !== (i == 5)) begin
                errors++;
                $display("FAIL drain_wait[%0d]: got busy=%b done=%b required 1 %b", i, busy, tile_done, (i == 5));
            end
        end
        @(negedge clock);
        credit_return = '0;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || tile_done !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: got busy=%b done=%b required 0 0", busy, tile_done);
        end
        @(negedge clock);
        $display("test_drain done");
    endtask

    task automatic test_credit_err();
        int cnt;
        do_reset();
        credit_return = 4'b1000;
        @(posedge clock); #1;
        checks++;
        if (credit_err !== 1'b1) begin
            errors++;
            $display("FAIL cerr_set: got %b required 1", credit_err);
        end
        @(negedge clock);
        credit_return = '0;
        @(posedge clock); @(posedge clock); #1;
        checks++;
        if (credit_err !== 1'b1) begin
            errors++;
            $display("FAIL cerr_sticky: got %b required 1", credit_err);
        end
        @(negedge clock);
        begin_tile();
        req_valid  = 4'b1000;
        req_dst[3] = 2'd3;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (grant[3]) cnt++;
            @(posedge clock);
            @(negedge clock);
        end
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("FAIL cerr_counter_capped: got %0d grants required 4", cnt);
        end
        req_valid = '0;
        do_reset();
        #1;
        checks++;
        if (credit_err !== 1'b0) begin
            errors++;
            $display("FAIL cerr_reset_clear: got %b required 0", credit_err);
        end
        $display("test_credit_err done");
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_reset();
        begin_tile();
        req_valid = 4'b0011;
        req_dst   = '0;
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_first: got grant=%b required 0001", grant);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({busy, grant, dst_valid, src_stall} !== {1'b0, 4'b0, 4'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b grant=%b dv=%b stall=%b required 0 0000 0000 1", busy, grant, dst_valid, src_stall);
        end
        @(negedge clock);
        reset = 1'b0;
        begin_tile();
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_restart_rr: got grant=%b required 0001", grant);
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (grant != 4'b0) cnt++;
            @(posedge clock);
            @(negedge clock);
        end
        checks++;
        if (cnt !== 4) begin
            errors++;
            $display("FAIL mid_credits: got %0d grants required 4", cnt);
        end
        req_valid = '0;
        $display("test_reset_mid done");
    endtask

    // Model: state 0=idle 1=active 2=drain 3=done; banks track free slots and priority source.
    task automatic test_random(input int ncyc);
        int         m_state, m_next;
        int         m_credit[4];
        int         m_rr[4];
        bit         m_err;
        bit         pend[4];
        int         pdst[4];
        bit         ehit[4];
        int         ewin[4];
        int         eds[4];
        logic [3:0] eg, edv;
        bit         estall, allfull, anyreq, st, fl;
        int         s;
        do_reset();
        m_state = 0; m_err = 1'b0;
        for (int d = 0; d < 4; d++) begin
            m_credit[d] = 4; m_rr[d] = 0; eds[d] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0; pdst[i] = 0;
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && m_state != 2 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdst[i] = int'($urandom_range(0, 3));
                end
                req_valid[i] = pend[i];
                req_dst[i]   = 2'(pdst[i]);
            end
            for (int d = 0; d < 4; d++) begin
                credit_return[d] = (m_credit[d] < 4 && $urandom_range(0, 2) == 0) ||
                                   ($urandom_range(0, 149) == 0);
            end
            st = ($urandom_range(0, 11) == 0);
            fl = (m_state == 1 && $urandom_range(0, 24) == 0) || ($urandom_range(0, 59) == 0);
            start = st;
            flush = fl;

            eg = '0;
            for (int d = 0; d < 4; d++) begin
                ehit[d] = 1'b0;
                ewin[d] = 0;
                if ((m_state == 1 || m_state == 2) && m_credit[d] > 0) begin
                    for (int k = 0; k < 4; k++) begin
                        s = (m_rr[d] + k) % 4;
                        if (!ehit[d] && pend[s] && pdst[s] == d) begin
                            ehit[d] = 1'b1;
                            ewin[d] = s;
                        end
                    end
                end
                if (ehit[d]) eg[ewin[d]] = 1'b1;
            end
            estall = |(req_valid & ~eg);
            #1;
            checks++;
            if (grant !== eg || src_stall !== estall) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got grant=%b stall=%b required %b %b", cyc, grant, src_stall, eg, estall);
            end
            if (eg != 4'b0) $display("txn cyc=%0d grant=%b", cyc, eg);

            allfull = 1'b1;
            for (int d = 0; d < 4; d++) if (m_credit[d] != 4) allfull = 1'b0;
            anyreq = |req_valid;
            m_next = m_state;
            case (m_state)
                0: if (st) m_next = 1;
                1: if (fl) m_next = 2;
                2: if (!anyreq && allfull) m_next = 3;
                default: m_next = 0;
            endcase
            m_state = m_next;
            for (int d = 0; d < 4; d++) begin
                edv[d] = ehit[d];
                if (ehit[d] && !credit_return[d]) m_credit[d]--;
                else if (!ehit[d] && credit_return[d]) begin
                    if (m_credit[d] == 4) m_err = 1'b1;
                    else m_credit[d]++;
                end
                if (ehit[d]) begin
                    m_rr[d] = (ewin[d] + 1) % 4;
                    eds[d]  = ewin[d];
                    pend[ewin[d]] = 1'b0;
                end
            end

            @(posedge clock); #1;
            checks++;
            if (dst_valid !== edv || busy !== (m_state != 0) || tile_done !== (m_state == 3) ||
                credit_err !== m_err) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got dv=%b busy=%b done=%b err=%b required %b %b %b %b",
                         cyc, dst_valid, busy, tile_done, credit_err, edv, (m_state != 0), (m_state == 3), m_err);
            end
            for (int d = 0; d < 4; d++) begin
                if (edv[d]) begin
                    checks++;
                    if (dst_src[d] !== 2'(eds[d])) begin
                        errors++;
                        $display("FAIL rand_src[%0d] bank %0d: got %0d required %0d", cyc, d, dst_src[d], eds[d]);
                    end
                end
            end
            @(negedge clock);
        end
        start = 1'b0; flush = 1'b0; req_valid = '0; credit_return = '0;
        $display("test_random done");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        req_valid = '0; req_dst = '0; credit_return = '0;
        test_reset();
        test_rr_same_bank();
        test_credit_exhaust();
        test_parallel();
        test_drain();
        test_credit_err();
        test_reset_mid();
        test_random(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_bank_arbiter.md
XBAR_BANK_ARBITER -- requirements
Module: xbar_bank_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of multiplier-output requesters.
REQ-002 Parameter NUM_DST, default 4, number of accumulate-buffer banks; power of two.
REQ-003 Parameter CREDITS, default 4, per-bank receive slots; CW = $clog2(CREDITS+1).
REQ-004 clock  in  1  clock; all state updates on posedge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle pulse; begins a tile.
REQ-007 flush  in  1  single-cycle pulse; last product of the tile has been presented.
REQ-008 req_valid  in  NUM_SRC  source s holds a product; held with req_dst until granted.
REQ-009 req_dst  in  NUM_SRC x $clog2(NUM_DST)  target bank per source (y mod NUM_DST).
REQ-010 credit_return  in  NUM_DST  bank d freed one slot this cycle.
REQ-011 grant  out  NUM_SRC  combinational; source s is accepted this cycle.
REQ-012 dst_valid  out  NUM_DST  registered; bank d receives a product this cycle.
REQ-013 dst_src  out  NUM_DST x $clog2(NUM_SRC)  registered; winning source index for bank d.
REQ-014 src_stall  out  1  combinational; some req_valid is high without grant.
REQ-015 busy  out  1  state != IDLE.
REQ-016 tile_done  out  1  registered single-cycle pulse at tile completion.
REQ-017 credit_err  out  1  sticky; credit_return seen at full credit.

Function
REQ-018 FSM states IDLE, ACTIVE, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE -> ACTIVE on start; start in any other state ignored.
REQ-020 ACTIVE -> DRAIN on flush; flush in IDLE/DRAIN/DONE ignored.
REQ-021 DRAIN -> DONE when no req_valid high and every credit counter == CREDITS in the same cycle.
REQ-022 DONE -> IDLE unconditionally after one cycle; tile_done high exactly during the DONE cycle.
REQ-023 Grants issue only in ACTIVE or DRAIN; grant all-zero in IDLE and DONE.
REQ-024 Per bank d: candidates = sources with req_valid and req_dst == d; at most one grant per bank per cycle.
REQ-025 Bank d grants only when credit[d] > 0.
REQ-026 Round-robin per bank: rr_ptr[d] names highest-priority source, search ascending with wrap; reset value 0.
REQ-027 On grant to s at bank d, rr_ptr[d] <= (s+1) mod NUM_SRC; unchanged if no grant at d.
REQ-028 Latency: grant in cycle N -> dst_valid[d]=1, dst_src[d]=s in cycle N+1; dst_valid low otherwise.
REQ-029 credit[d] reset CREDITS; -1 on grant, +1 on credit_return; both same cycle -> unchanged.
REQ-030 credit_return at credit[d]==CREDITS with no grant: counter holds CREDITS, credit_err set until reset.
REQ-031 Credit at 0 with credit_return same cycle: no grant that cycle (decision uses registered count).
REQ-032 src_stall = OR over s of (req_valid[s] & ~grant[s]), including IDLE/DONE.
REQ-033 Credits persist across tiles; not reinitialised at start.

Reset
REQ-034 Reset mid-operation aborts tile: state IDLE, rr_ptr 0, credits CREDITS, dst_valid 0, dst_src 0, tile_done 0, credit_err 0, busy 0.
REQ-035 Outputs after reset: grant 0 and src_stall = OR of req_valid until start.

Verification
REQ-036 start; sources 0-3 all req_dst=1, held -> grants s0,s1,s2,s3 in consecutive cycles; dst_valid[1] one cycle later each, dst_src 0,1,2,3.
REQ-037 CREDITS=4, no returns, source 0 to bank 2 for 6 cycles -> 4 grants, then grant 0, src_stall 1; one credit_return -> one more grant next cycle.
REQ-038 Sources 0-3 to banks 0-3 distinct -> all four granted same cycle, dst_valid=4'b1111 next cycle.
REQ-039 flush with 2 credits outstanding on bank 0 -> stays DRAIN; second credit_return -> DONE next cycle, tile_done one-cycle pulse, then IDLE.
REQ-040 credit_return[3] with credit[3]==4 -> credit_err 1 and held; counter stays 4; reset clears.
REQ-041 Reset during ACTIVE with pending requests -> next cycle busy 0, grant 0, credits 4, rr_ptr 0 (s0 wins first after restart).
